// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin owner selection for a shared 4:1 bit-select mux.
// Drives a registered one-hot grant plus the matching 2-bit mux select. A
// one-cycle TURN state sits between owners, so the select only moves on the
// edge that enters GRANT.
// Optional build macro MUX_ARB_TIMEOUT_EN adds a hold counter. When the
// counter has expired and a competitor is waiting, the owner is forcibly
// released and a one-cycle preempt pulse is produced. Without the macro,
// preempt stays low.
// Handshake: req[i] is a level request. The owner keeps grant for as long as
// it holds req[i]. Dropping req[i] is the only voluntary release, and a
// request that drops before it is granted is not remembered.
module mux_sel_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] control,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // state is left as a named signal so checkers can bind to it directly
  state_t     state;
  state_t     state_nxt;
  logic [1:0] ptr;
  logic [1:0] ptr_nxt;
  logic [3:0] grant_nxt;
  logic [1:0] control_nxt;
  logic       busy_nxt;
  logic       preempt_nxt;
  logic [1:0] winner;
  logic       owner_req;
  logic       others_req;
  logic       hold_expired;

  // control always holds the current (or last) owner index
  assign owner_req  = req[control];
  assign others_req = |(req & ~grant);

  // Round-robin scan: first requester at ptr, ptr+1, ... modulo 4
  always_comb begin
    logic       found;
    logic [1:0] idx;
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_MAX);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Counter at or past its last allowed value stays expired, so a late
  // competitor still wins at the first edge it is seen
  assign hold_expired = (cnt >= HOLD_LAST) && others_req;

  // Hold counter: cleared while idle, counts GRANT cycles, saturates
  always_comb begin
    cnt_nxt = cnt;
    if (state == IDLE) begin
      cnt_nxt = '0;
    end else if (state == GRANT && cnt != HOLD_SAT) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Hold counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end
`else
  assign hold_expired = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^{HOLD_MAX, CNT_W, others_req};
`endif

  // Next-state and registered-output decode
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    control_nxt = control;
    busy_nxt    = busy;
    preempt_nxt = 1'b0;
    ptr_nxt     = ptr;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt   = 4'b0001 << winner;
          control_nxt = winner;
          busy_nxt    = 1'b1;
          state_nxt   = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req || hold_expired) begin
          grant_nxt   = 4'b0000;
          busy_nxt    = 1'b0;
          ptr_nxt     = control + 2'd1;
          state_nxt   = TURN;
          preempt_nxt = owner_req;
        end
      end
      TURN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'b0000;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= 4'b0000;
      control <= 2'b00;
      busy    <= 1'b0;
      preempt <= 1'b0;
      ptr     <= 2'b00;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      control <= control_nxt;
      busy    <= busy_nxt;
      preempt <= preempt_nxt;
      ptr     <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed bench for mux_sel_arbiter.
// Each step drives req, queues the expected {grant, control, busy, preempt}
// for the following edge, then pops and compares it #1 after that edge.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] control;
  logic       busy;
  logic       preempt;

  logic [7:0] exp_q[$];
  int         n_tests;
  int         n_fail;

  mux_sel_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .grant   (grant),
    .control (control),
    .busy    (busy),
    .preempt (preempt)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ex(input logic [3:0] g, input logic [1:0] c,
                                    input logic b, input logic p);
    return {g, c, b, p};
  endfunction

  task automatic check(input string tag);
    logic [7:0] obs;
    logic [7:0] e;
    e   = exp_q.pop_front();
    obs = {grant, control, busy, preempt};
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed={g,c,b,p}=%h expected=%h", tag, obs, e);
    end
  endtask

  // drive req, wait one edge, compare against queued expectation
  task automatic cycle(input logic [3:0] r, input logic [7:0] e, input string tag);
    req = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  // synchronous-looking reset pulse with outputs checked while held
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    req   = 4'b0000;
    @(posedge clk);
    #1;
    exp_q.push_back(ex(4'b0000, 2'd0, 1'b0, 1'b0));
    check(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] oh;
    logic [3:0] oh_n;
    logic [1:0] ctl;
    logic [1:0] ctl_n;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req     = 4'b0000;

    // reset state, then single requester 2
    do_reset("reset_outputs");
    cycle(4'b0100, ex(4'b0100, 2'd2, 1'b1, 1'b0), "first_grant_2");
    cycle(4'b0000, ex(4'b0000, 2'd2, 1'b0, 1'b0), "release_2_turn");
    cycle(4'b0000, ex(4'b0000, 2'd2, 1'b0, 1'b0), "idle_keeps_control");

    // all four requesting: strict rotation with two empty cycles between grants
    do_reset("reset_before_rr");
    cycle(4'b1111, ex(4'b0001, 2'd0, 1'b1, 1'b0), "rr_first_0");
    for (int k = 0; k < 4; k++) begin
      oh    = 4'b0001 << k;
      ctl   = 2'(k);
      ctl_n = 2'(k + 1);
      oh_n  = 4'b0001 << ctl_n;
      cycle(4'b1111, ex(oh, ctl, 1'b1, 1'b0), $sformatf("rr_hold_a_%0d", k));
      cycle(4'b1111, ex(oh, ctl, 1'b1, 1'b0), $sformatf("rr_hold_b_%0d", k));
      cycle(4'b1111 & ~oh, ex(4'b0000, ctl, 1'b0, 1'b0), $sformatf("rr_turn_%0d", k));
      cycle(4'b1111, ex(4'b0000, ctl, 1'b0, 1'b0), $sformatf("rr_idle_%0d", k));
      cycle(4'b1111, ex(oh_n, ctl_n, 1'b1, 1'b0), $sformatf("rr_next_%0d", k));
    end

    // owner 0 -> owner 3 chosen from ptr=1, then owner 3 releases, 1001 wraps to 0
    cycle(4'b1000, ex(4'b0000, 2'd0, 1'b0, 1'b0), "rel0_turn");
    cycle(4'b1000, ex(4'b0000, 2'd0, 1'b0, 1'b0), "rel0_idle");
    cycle(4'b1001, ex(4'b1000, 2'd3, 1'b1, 1'b0), "win3_from_ptr1");
    cycle(4'b1001, ex(4'b1000, 2'd3, 1'b1, 1'b0), "hold3_ignores_0");
    cycle(4'b0001, ex(4'b0000, 2'd3, 1'b0, 1'b0), "rel3_turn");
    cycle(4'b1001, ex(4'b0000, 2'd3, 1'b0, 1'b0), "rel3_idle");
    cycle(4'b1001, ex(4'b0001, 2'd0, 1'b1, 1'b0), "wrap_to_0");

    // owner 2 releases (ptr=3), req 0011 scans 3,0 -> 0
    cycle(4'b0100, ex(4'b0000, 2'd0, 1'b0, 1'b0), "rel0b_turn");
    cycle(4'b0100, ex(4'b0000, 2'd0, 1'b0, 1'b0), "rel0b_idle");
    cycle(4'b0100, ex(4'b0100, 2'd2, 1'b1, 1'b0), "win2");
    cycle(4'b0011, ex(4'b0000, 2'd2, 1'b0, 1'b0), "rel2_turn");
    cycle(4'b0011, ex(4'b0000, 2'd2, 1'b0, 1'b0), "rel2_idle");
    cycle(4'b0011, ex(4'b0001, 2'd0, 1'b1, 1'b0), "ptr3_wrap_to_0");

    // get owner 2 again, then asynchronous reset between edges
    cycle(4'b0100, ex(4'b0000, 2'd0, 1'b0, 1'b0), "rel0c_turn");
    cycle(4'b0100, ex(4'b0000, 2'd0, 1'b0, 1'b0), "rel0c_idle");
    cycle(4'b0100, ex(4'b0100, 2'd2, 1'b1, 1'b0), "win2_again");
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(ex(4'b0000, 2'd0, 1'b0, 1'b0));
    check("async_reset_mid_grant");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(4'b0010, ex(4'b0010, 2'd1, 1'b1, 1'b0), "after_reset_grant_1");

    // owner 0 holds while req[2] arrives during its third GRANT cycle
    do_reset("reset_before_hold");
    cycle(4'b0001, ex(4'b0001, 2'd0, 1'b1, 1'b0), "hold_g1");
    for (int k = 2; k <= 8; k++) begin
      cycle((k >= 4) ? 4'b0101 : 4'b0001, ex(4'b0001, 2'd0, 1'b1, 1'b0),
            $sformatf("hold_g%0d", k));
    end
`ifdef MUX_ARB_TIMEOUT_EN
    cycle(4'b0101, ex(4'b0000, 2'd0, 1'b0, 1'b1), "preempt_pulse");
    cycle(4'b0101, ex(4'b0000, 2'd0, 1'b0, 1'b0), "preempt_idle");
    cycle(4'b0101, ex(4'b0100, 2'd2, 1'b1, 1'b0), "preempt_regrant_2");
`else
    for (int k = 9; k <= 20; k++) begin
      cycle(4'b0101, ex(4'b0001, 2'd0, 1'b1, 1'b0), $sformatf("no_preempt_g%0d", k));
    end
`endif

    // sole requester 1 holds 20 cycles without preemption
    do_reset("reset_before_sole");
    cycle(4'b0010, ex(4'b0010, 2'd1, 1'b1, 1'b0), "sole_g1");
    for (int k = 2; k <= 21; k++) begin
      cycle(4'b0010, ex(4'b0010, 2'd1, 1'b1, 1'b0), $sformatf("sole_g%0d", k));
    end
`ifdef MUX_ARB_TIMEOUT_EN
    cycle(4'b0011, ex(4'b0000, 2'd1, 1'b0, 1'b1), "saturated_preempt");
`else
    cycle(4'b0011, ex(4'b0010, 2'd1, 1'b1, 1'b0), "competitor_ignored");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
